crc_append_mp: RTL

//  Serial CRC generator/appender/checker for the bit-serial packet path. It sits between the
//  bit stuffer/PID stage and NRZI. Two modes:
//  - Append mode: covered bits pass through unchanged, then the complemented CRC is appended.
//  - Check mode: a received stream's residual is compared and crc_ok/crc_err is flagged.
//  CRC5 or CRC16 is chosen per packet. pause_out back-pressure is honoured in every state.

---
 rtl/crc_append_mp.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/crc_append_mp.sv
// crc_append_mp: serial CRC5/CRC16 generator, appender and checker.
// The block sits on the bit-serial packet path. In append mode it passes the
// covered bits through and then emits the complemented CRC, MSB first. In check
// mode it compares the received residual and pulses crc_ok or crc_err.
module crc_append_mp #(
    parameter logic [4:0]  POLY5  = 5'h05,
    parameter logic [15:0] POLY16 = 16'h8005,
    parameter logic [4:0]  RES5   = 5'b01100,
    parameter logic [15:0] RES16  = 16'h800D
) (
    input  logic clk,
    input  logic rst_L,
    input  logic inb,
    input  logic recving,
    input  logic start,
    input  logic crc16_sel,
    input  logic chk_mode,
    input  logic pause_out,
    output logic pause_in,
    output logic outb,
    output logic sending,
    output logic crc_ok,
    output logic crc_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel16_q, sel16_d;
    logic        chk_q, chk_d;

    logic        consume;
    logic        crcMsb;
    logic [3:0]  lastIdx;
    logic        residualOk;

    // One Galois LFSR step. In CRC5 mode only bits [4:0] take part; the
    // upper bits are carried along untouched and never observed.
    function automatic logic [15:0] lfsrStep(input logic [15:0] crc,
                                             input logic bitIn,
                                             input logic is16);
        logic [15:0] nxt;
        logic        fb;
        nxt = crc;
        if (is16) begin
            fb  = bitIn ^ crc[15];
            nxt = {crc[14:0], 1'b0} ^ (fb ? POLY16 : 16'h0000);
        end else begin
            fb       = bitIn ^ crc[4];
            nxt[4:0] = {crc[3:0], 1'b0} ^ (fb ? POLY5 : 5'h00);
        end
        return nxt;
    endfunction

    assign consume    = recving & ~pause_out;
    assign crcMsb     = sel16_q ? crc_q[15] : crc_q[4];
    assign lastIdx    = sel16_q ? 4'd15 : 4'd4;
    assign residualOk = sel16_q ? (crc_q == RES16) : (crc_q[4:0] == RES5);

    // State, CRC register, bit counter and the per-packet mode latches.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= IDLE;
            crc_q   <= 16'hFFFF;
            cnt_q   <= 4'd0;
            sel16_q <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            sel16_q <= sel16_d;
            chk_q   <= chk_d;
        end
    end

    // Next state plus datapath update; nothing advances while a bit is not consumed.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        sel16_d = sel16_q;
        chk_d   = chk_q;
        case (state_q)
            IDLE: begin
                crc_d = 16'hFFFF;
                if (consume && !start) begin
                    sel16_d = crc16_sel;
                    chk_d   = chk_mode;
                    crc_d   = lfsrStep(16'hFFFF, inb, crc16_sel);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (recving) begin
                    if (!pause_out) begin
                        crc_d = lfsrStep(crc_q, inb, sel16_q);
                    end
                end else if (chk_q) begin
                    crc_d   = 16'hFFFF;
                    state_d = IDLE;
                end else begin
                    // The first CRC bit goes out in this same cycle, so a
                    // consumed bit here already counts as CRC bit 0.
                    state_d = SEND;
                    if (!pause_out) begin
                        crc_d = {crc_q[14:0], 1'b0};
                        cnt_d = 4'd1;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            SEND: begin
                if (!pause_out) begin
                    if (cnt_q == lastIdx) begin
                        crc_d   = 16'hFFFF;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        crc_d = {crc_q[14:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = 16'hFFFF;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Serial output, handshakes and check-mode result pulses.
    always_comb begin
        outb     = 1'b0;
        sending  = 1'b0;
        pause_in = 1'b0;
        crc_ok   = 1'b0;
        crc_err  = 1'b0;
        case (state_q)
            IDLE: begin
                outb    = inb;
                sending = recving;
            end
            CALC: begin
                if (recving) begin
                    outb    = inb;
                    sending = 1'b1;
                end else if (chk_q) begin
                    crc_ok  = residualOk;
                    crc_err = ~residualOk;
                end else begin
                    outb     = ~crcMsb;
                    sending  = 1'b1;
                    pause_in = 1'b1;
                end
            end
            SEND: begin
                outb     = ~crcMsb;
                sending  = 1'b1;
                pause_in = 1'b1;
            end
            default: begin
                outb = 1'b0;
            end
        endcase
    end

endmodule
